// File: rtl/fir_stream_feeder_if.sv
// Stream bundle for fir_stream_feeder: input samples, output results and the
// sample/enable/result lines of the time-multiplexed FIR filter.
interface fir_stream_feeder_if #(
    parameter int WIDTH = 18
);
    logic signed [WIDTH-1:0] s_data;
    logic                    s_valid;
    logic                    s_ready;
    logic signed [WIDTH-1:0] fir_in;
    logic                    fir_ready;
    logic signed [WIDTH-1:0] fir_out;
    logic signed [WIDTH-1:0] m_data;
    logic                    m_valid;
    logic                    m_ready;

    // The feeder side.
    modport slave (
        input  s_data, s_valid, fir_out, m_ready,
        output s_ready, fir_in, fir_ready, m_data, m_valid
    );

    // The environment side: sample source, result sink and the filter.
    modport master (
        output s_data, s_valid, fir_out, m_ready,
        input  s_ready, fir_in, fir_ready, m_data, m_valid
    );
endinterface

// File: rtl/fir_stream_feeder.sv
// Flow-control wrapper around a time-multiplexed FIR: buffers input samples,
// presents each one to the filter for a whole TAPS-cycle frame, returns results.
module fir_stream_feeder #(
    parameter int WIDTH      = 18,
    parameter int TAPS       = 64,
    parameter int FIFO_DEPTH = 4
) (
    input logic                clk,
    input logic                rst_n,
    fir_stream_feeder_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PH_W  = $clog2(TAPS);

    typedef enum logic {IDLE, RUN} state_t;

    logic signed [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    state_t                  state_q, state_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic                    first_q, first_d;
    logic signed [WIDTH-1:0] fir_in_q, fir_in_d;
    logic signed [WIDTH-1:0] m_data_q, m_data_d;
    logic                    m_valid_q, m_valid_d;

    logic s_ready;
    logic push;
    logic pop;
    logic start;
    logic last_phase;
    logic capture;
    logic fir_ready;

    assign s_ready    = (count_q != CNT_W'(FIFO_DEPTH));
    assign push       = bus.s_valid & s_ready;
    // A new frame may begin only when the output slot is free or being freed.
    assign start      = (count_q != '0) && (!m_valid_q || bus.m_ready);
    assign last_phase = (phase_q == PH_W'(TAPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    phase_d = '0;
                end
            end
            RUN: begin
                if (!last_phase) begin
                    phase_d = phase_q + PH_W'(1);
                end else if (start) begin
                    phase_d = '0;
                end else begin
                    state_d = IDLE;
                    phase_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    always_comb begin
        fir_ready = (state_q == RUN);
        pop       = start && ((state_q == IDLE) || last_phase);
        // The filter publishes the previous sample's result during phase 0.
        capture   = (state_q == RUN) && (phase_q == PH_W'(1)) && !first_q;
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        fir_in_d  = pop  ? mem_q[rd_ptr_q] : fir_in_q;
        first_d   = ((state_q == RUN) && (phase_q == PH_W'(1))) ? 1'b0 : first_q;
        m_data_d  = capture ? bus.fir_out : m_data_q;
        m_valid_d = m_valid_q;
        if (capture) begin
            m_valid_d = 1'b1;
        end else if (m_valid_q && bus.m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            first_q   <= 1'b1;
            fir_in_q  <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            first_q   <= first_d;
            fir_in_q  <= fir_in_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
        end
    end

    // Storage holds data only; occupancy is tracked by count and pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.s_data;
        end
    end

    assign bus.s_ready   = s_ready;
    assign bus.fir_ready = fir_ready;
    assign bus.fir_in    = fir_in_q;
    assign bus.m_data    = m_data_q;
    assign bus.m_valid   = m_valid_q;
endmodule

// File: doc/fir_stream_feeder.md
# fir_stream_feeder

Streaming front/back end for the time-multiplexed 64-tap FIR filter. It accepts input samples over a valid/ready handshake and buffers them in a small FIFO. It drives the filter's sample/enable pair one frame of TAPS enabled cycles per sample, and returns each filtered result over a valid/ready handshake. It owns all flow control, so the filter only ever sees whole, aligned frames.

## Interface
- WIDTH, 18: sample width, signed, two's complement.
- TAPS, 64: enabled cycles per filter frame. Must equal the filter tap count; power of two.
- FIFO_DEPTH, 4: input FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_data  in  WIDTH  input sample.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO not full; a sample transfers on an edge with s_valid & s_ready.
- fir_in  out  WIDTH  to the filter's input_sig.
- fir_ready  out  1  to the filter's ready (enable).
- fir_out  in  WIDTH  from the filter's filtred_sig.
- m_data  out  WIDTH  filtered sample.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts; transfers on m_valid & m_ready.

## Operation
- FIFO: registered count and pointers that wrap modulo FIFO_DEPTH.
  - s_ready = (count != FIFO_DEPTH), combinational from the count only, with no same-cycle pass-through when full.
  - A push and a pop on the same edge leave count unchanged.
- State machine IDLE/RUN; a phase counter runs 0..TAPS-1.
  - Start condition: FIFO not empty AND (m_valid == 0 OR m_ready == 1).
  - IDLE: if start, go to RUN with phase 0, pop the FIFO head into fir_in, and set fir_ready = 1. Otherwise fir_ready = 0.
  - RUN: fir_ready = 1 and phase increments each cycle. fir_in is held for the whole frame.
  - At phase TAPS-1: if start holds, wrap to phase 0 with the next sample (back-to-back, no gap). Otherwise go to IDLE with fir_ready = 0.
- The filter writes its sample and updates its result in the phase-0 cycle. The result at frame n's phase 0 is the response to sample n-1.
  - The feeder captures fir_out into m_data and sets m_valid in the phase-1 cycle.
  - The capture in the first frame after reset is skipped, controlled by a first-frame flag that is set by reset and cleared at the first phase 1.
- m_valid clears on m_valid & m_ready. It is never overwritten while set, which the start condition guarantees.
- The response to the last sample is emitted only when a further sample is framed. This behaviour is intended.
- Integration requirement: the filter's tap index must be at its initial value whenever rst_n deasserts. Reset the feeder only together with a filter reconfiguration.

## Timing
- Reset values: s_ready = 1 after the FIFO clears, fir_ready = 0, fir_in = 0, m_valid = 0, m_data = 0, state IDLE, phase 0, count 0, first-frame flag = 1.
- Asserting rst_n low mid-frame forces fir_ready low immediately (asynchronous) and drops the FIFO contents.
- Latency, feeder idle and FIFO empty: a sample accepted at edge E appears on fir_in with fir_ready = 1 in the cycle after edge E+1.
- Frame length: exactly TAPS consecutive fir_ready = 1 cycles. fir_ready never drops mid-frame, and frames are never partial.
- Throughput: one sample per TAPS clocks while input is available and output is drained.
- Output: m_valid rises at the edge ending phase 1 of frame n+1, carrying the response to sample n.
- Backpressure: m_valid = 1 with m_ready = 0 at a frame boundary holds fir_ready = 0, which freezes the filter. Framing resumes on the edge after m_ready rises.

## Test plan
- Reset: assert rst_n low mid-run -> fir_ready = 0 asynchronously. After release: m_valid = 0, s_ready = 1, fir_in = 0.
- Single sample 100 -> fir_in = 100 and fir_ready = 1 for exactly 64 consecutive cycles, then fir_ready = 0. No m_valid pulse (first frame discarded).
- Samples 1000, then 0 back-to-back, checked against a behavioural filter model:
  - fir_ready is high for 128 consecutive cycles.
  - One m_valid pulse appears at phase 1 of frame 2, with m_data equal to the model output for sample 1000.
- Burst of 6 samples with s_valid held high from idle:
  - Sample 1 is framed.
  - Samples 2..5 fill the FIFO and s_ready drops.
  - Sample 6 waits until the next phase-0 pop, then is accepted.
- Backpressure: hold m_ready = 0 while m_valid = 1 with the FIFO non-empty -> at phase 63, fir_ready drops and fir_in holds. Raise m_ready -> m_valid clears and a new frame starts on the next edge.
- Reset at phase 30 of a frame with 3 samples queued -> FIFO empty after release. The next accepted sample 7 is framed without any m_valid pulse.
